// File: rtl/jtag_hold_arbiter.sv
// Hands the shared SRAM to the JTAG bridge through HOLD/HLDA. The CPU is drained
// first, and level write requests from the bridge become timed WE pulses.
module jtag_hold_arbiter #(
    parameter int WE_PULSE = 2,
    parameter int GUARD    = 1
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        iHOLD,
    output logic        oHLDA,
    input  logic        iCPU_BUSY,
    output logic        oCPU_STALL,
    input  logic [17:0] iCPU_ADDR,
    input  logic [15:0] iCPU_DATA,
    input  logic        iCPU_WE_N,
    input  logic        iCPU_OE_N,
    output logic [15:0] oCPU_DATA,
    input  logic [17:0] iJTAG_ADDR,
    input  logic [15:0] iJTAG_DATA,
    input  logic        iJTAG_WR_N,
    input  logic        iJTAG_SELECT,
    output logic [15:0] oJTAG_DATA_TO_HOST,
    output logic [17:0] oSRAM_ADDR,
    output logic [15:0] oSRAM_DQ_OUT,
    output logic        oSRAM_DQ_OE,
    output logic        oSRAM_WE_N,
    output logic        oSRAM_OE_N,
    input  logic [15:0] iSRAM_DQ_IN
);

    typedef enum logic [2:0] {
        IDLE, DRAIN, GRANT, WR_SETUP, WR_PULSE, WR_HOLD, RELEASE
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WE_PULSE - 1);
    // RELEASE always lasts at least one cycle, even with no guard time.
    localparam logic [3:0] GUARD_LAST = (GUARD > 1) ? 4'(GUARD - 1) : 4'd0;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        owner, owner_next;
    logic        hlda, stall, stall_next;
    logic        wr_n_prev, wr_fall, latch_en;
    logic [17:0] lat_addr;
    logic [15:0] lat_data;
    logic [15:0] host_data;

    assign wr_fall = wr_n_prev & ~iJTAG_WR_N;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (iHOLD) state_next = DRAIN;
            end
            DRAIN: begin
                // A withdrawn request wins so that HLDA never rises for it.
                if (!iHOLD) begin
                    state_next = RELEASE;
                    cnt_next   = GUARD_LAST;
                end else if (!iCPU_BUSY) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!iHOLD) begin
                    state_next = RELEASE;
                    cnt_next   = GUARD_LAST;
                end else if (wr_fall && iJTAG_SELECT) begin
                    state_next = WR_SETUP;
                    latch_en   = 1'b1;
                end
            end
            WR_SETUP: begin
                state_next = WR_PULSE;
                cnt_next   = PULSE_LAST;
            end
            WR_PULSE: begin
                if (cnt == 4'd0) state_next = WR_HOLD;
                else             cnt_next   = cnt - 4'd1;
            end
            WR_HOLD: begin
                state_next = GRANT;
            end
            RELEASE: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign owner_next = (state_next == GRANT) || (state_next == WR_SETUP) ||
                        (state_next == WR_PULSE) || (state_next == WR_HOLD);
    assign stall_next = (state_next != IDLE);

    always_ff @(posedge clk24) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner     <= 1'b0;
            hlda      <= 1'b0;
            stall     <= 1'b0;
            wr_n_prev <= 1'b1;
            lat_addr  <= 18'd0;
            lat_data  <= 16'd0;
            host_data <= 16'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            owner     <= owner_next;
            hlda      <= owner_next;
            stall     <= stall_next;
            wr_n_prev <= iJTAG_WR_N;
            if (latch_en) begin
                lat_addr <= iJTAG_ADDR;
                lat_data <= iJTAG_DATA;
            end
            if (state == GRANT) host_data <= iSRAM_DQ_IN;
        end
    end

    // The registered owner bit, not the state, picks the SRAM side, so the
    // mux only flips on edges where WE_N is already high.
    always_comb begin
        oSRAM_ADDR   = iCPU_ADDR;
        oSRAM_DQ_OUT = iCPU_DATA;
        oSRAM_WE_N   = iCPU_WE_N;
        oSRAM_OE_N   = iCPU_OE_N;
        oSRAM_DQ_OE  = ~iCPU_WE_N;
        if (owner) begin
            if (state == GRANT) begin
                oSRAM_ADDR   = iJTAG_ADDR;
                oSRAM_DQ_OUT = lat_data;
                oSRAM_WE_N   = 1'b1;
                oSRAM_OE_N   = 1'b0;
                oSRAM_DQ_OE  = 1'b0;
            end else begin
                oSRAM_ADDR   = lat_addr;
                oSRAM_DQ_OUT = lat_data;
                oSRAM_WE_N   = (state != WR_PULSE);
                oSRAM_OE_N   = 1'b1;
                oSRAM_DQ_OE  = 1'b1;
            end
        end
    end

    assign oHLDA              = hlda;
    assign oCPU_STALL         = stall;
    assign oCPU_DATA          = iSRAM_DQ_IN;
    assign oJTAG_DATA_TO_HOST = host_data;

endmodule
